// File: rtl/nonce_target_checker.sv
// nonce_target_checker: streams per-nonce H0 words from memory, finds the first word
// below target and the minimum word, then writes a two-word summary back and pulses done.
module nonce_target_checker #(
    parameter int NUM_NONCES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] result_addr,
    input  logic [15:0] status_addr,
    input  logic [31:0] target,
    output logic        done,
    output logic        found,
    output logic [7:0]  first_idx,
    output logic [31:0] min_value,
    output logic [7:0]  min_idx,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);
    typedef enum logic [2:0] {IDLE, FILL, STREAM, DRAIN, WR_STATUS, WR_MIN, DONE} state_t;
    localparam logic [8:0] LAST_ISSUE = 9'(NUM_NONCES);
    localparam logic [7:0] LAST_J = 8'(NUM_NONCES - 1);
    state_t      state;
    logic [15:0] base;
    logic [15:0] status_base;
    logic [31:0] tgt;
    logic [8:0]  issue_cnt;
    logic [7:0]  j;
    logic        more;
    logic        hit;
    logic        lower;
    assign mem_clk = clk;
    assign more = issue_cnt < LAST_ISSUE;
    assign hit = mem_read_data < tgt;
    // the first word always seeds the minimum; later words replace it only when strictly smaller
    assign lower = (j == 8'd0) || (mem_read_data < min_value);
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            done           <= 1'b0;
            found          <= 1'b0;
            first_idx      <= 8'd0;
            min_value      <= 32'hFFFF_FFFF;
            min_idx        <= 8'd0;
            mem_we         <= 1'b0;
            mem_addr       <= 16'd0;
            mem_write_data <= 32'd0;
            base           <= 16'd0;
            status_base    <= 16'd0;
            tgt            <= 32'd0;
            issue_cnt      <= 9'd0;
            j              <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    done   <= 1'b0;
                    mem_we <= 1'b0;
                    if (start) begin
                        base        <= result_addr;
                        status_base <= status_addr;
                        tgt         <= target;
                        mem_addr    <= result_addr;
                        issue_cnt   <= 9'd1;
                        j           <= 8'd0;
                        state       <= FILL;
                    end
                end
                FILL: begin
                    if (more) begin
                        mem_addr  <= base + 16'(issue_cnt);
                        issue_cnt <= issue_cnt + 9'd1;
                    end
                    found     <= 1'b0;
                    first_idx <= 8'd0;
                    state     <= STREAM;
                end
                STREAM, DRAIN: begin
                    if (lower) begin
                        min_value <= mem_read_data;
                        min_idx   <= j;
                    end
                    if (hit && !found) begin
                        found     <= 1'b1;
                        first_idx <= j;
                    end
                    if (more) begin
                        mem_addr  <= base + 16'(issue_cnt);
                        issue_cnt <= issue_cnt + 9'd1;
                    end
                    j     <= j + 8'd1;
                    state <= (j == LAST_J) ? WR_STATUS : (more ? STREAM : DRAIN);
                end
                WR_STATUS: begin
                    mem_we         <= 1'b1;
                    mem_addr       <= status_base;
                    mem_write_data <= {found, 15'b0, first_idx, min_idx};
                    state          <= WR_MIN;
                end
                WR_MIN: begin
                    mem_addr       <= status_base + 16'd1;
                    mem_write_data <= min_value;
                    state          <= DONE;
                end
                DONE: begin
                    mem_we <= 1'b0;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nonce_target_checker.sv
// tb_nonce_target_checker: randomized and directed scans against a loop-based reference
// model over a behavioural two-cycle-latency memory.
module tb_nonce_target_checker;
    localparam int N = 16;
    logic        clk = 0;
    logic        reset_n = 0;
    logic        start = 0;
    logic [15:0] result_addr = 0;
    logic [15:0] status_addr = 0;
    logic [31:0] target = 0;
    logic        done, found, mem_clk, mem_we;
    logic [7:0]  first_idx, min_idx;
    logic [31:0] min_value, mem_write_data;
    logic [15:0] mem_addr;
    logic [31:0] mem_read_data = 0;
    logic [31:0] mem [0:65535];
    int          vectors = 0;
    int          miscompares = 0;
    int          writes = 0;
    int          bad_writes = 0;
    logic [15:0] cur_sa = 0;

    nonce_target_checker #(.NUM_NONCES(N)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .result_addr(result_addr),
        .status_addr(status_addr), .target(target), .done(done), .found(found),
        .first_idx(first_idx), .min_value(min_value), .min_idx(min_idx), .mem_clk(mem_clk),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // registered read: data for an address registered at edge n is sampled by the DUT at n+2
    always @(posedge mem_clk) begin
        mem_read_data <= mem[mem_addr];
        if (mem_we) begin
            mem[mem_addr] <= mem_write_data;
            writes++;
            if (mem_addr != cur_sa && mem_addr != cur_sa + 16'd1) bad_writes++;
        end
    end

    function automatic void model(input logic [15:0] b, input logic [31:0] tg, output logic f,
                                  output logic [7:0] fi, output logic [31:0] mv, output logic [7:0] mi);
        logic [31:0] w;
        f = 0; fi = 0; mv = '1; mi = 0;
        for (int i = 0; i < N; i++) begin
            w = mem[b + 16'(i)];
            if (w < tg && !f) begin f = 1; fi = 8'(i); end
            if (i == 0 || w < mv) begin mv = w; mi = 8'(i); end
        end
    endfunction

    task automatic run_scan(input logic [15:0] ra, input logic [15:0] sa, input logic [31:0] tg, output int lat);
        cur_sa = sa;
        @(negedge clk);
        result_addr = ra; status_addr = sa; target = tg; start = 1;
        @(posedge clk);
        #1 start = 0;
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!done && lat < 400);
    endtask

    task automatic test_reset;
        vectors++;
        if ({done, found, first_idx, min_value, min_idx, mem_we, mem_addr, mem_write_data} !==
            {1'b0, 1'b0, 8'd0, 32'hFFFF_FFFF, 8'd0, 1'b0, 16'd0, 32'd0}) begin
            miscompares++;
            $display("FAIL reset: got done=%b found=%b fi=%0d mv=%h mi=%0d we=%b addr=%h wd=%h", done, found,
                     first_idx, min_value, min_idx, mem_we, mem_addr, mem_write_data);
        end
    endtask

    task automatic test_ascending;
        int lat;
        for (int i = 0; i < N; i++) mem[16'h0100 + 16'(i)] = 32'h1000_0000 + 32'(i * 16);
        run_scan(16'h0100, 16'h9000, 32'h1000_0035, lat);
        vectors++;
        if (lat !== N + 4) begin miscompares++; $display("FAIL asc_latency: got %0d want %0d", lat, N + 4); end
        vectors++;
        if ({found, first_idx, min_value, min_idx} !== {1'b1, 8'd0, 32'h1000_0000, 8'd0}) begin
            miscompares++;
            $display("FAIL asc_result: got f=%b fi=%0d mv=%h mi=%0d want 1 0 10000000 0", found, first_idx, min_value, min_idx);
        end
        vectors++;
        if ({mem[16'h9000], mem[16'h9001]} !== {32'h8000_0000, 32'h1000_0000}) begin
            miscompares++;
            $display("FAIL asc_status: got %h %h want 80000000 10000000", mem[16'h9000], mem[16'h9001]);
        end
    endtask

    task automatic test_strict;
        int lat;
        for (int i = 0; i < N; i++) mem[16'h0200 + 16'(i)] = (i == 9) ? 32'h100 : 32'hFFFF_FFFF;
        run_scan(16'h0200, 16'h9010, 32'h100, lat);
        vectors++;
        if ({found, first_idx, min_value, min_idx} !== {1'b0, 8'd0, 32'h100, 8'd9}) begin
            miscompares++;
            $display("FAIL strict_result: got f=%b fi=%0d mv=%h mi=%0d want 0 0 100 9", found, first_idx, min_value, min_idx);
        end
        vectors++;
        if ({mem[16'h9010], mem[16'h9011]} !== {32'h0000_0009, 32'h100}) begin
            miscompares++;
            $display("FAIL strict_status: got %h %h want 00000009 00000100", mem[16'h9010], mem[16'h9011]);
        end
    endtask

    task automatic test_ties;
        int lat;
        for (int i = 0; i < N; i++) mem[16'h0300 + 16'(i)] = (i == 3 || i == 11) ? 32'd5 : 32'h1000 + 32'(i);
        run_scan(16'h0300, 16'h9020, 32'h10, lat);
        vectors++;
        if ({found, first_idx, min_value, min_idx} !== {1'b1, 8'd3, 32'd5, 8'd3}) begin
            miscompares++;
            $display("FAIL ties_result: got f=%b fi=%0d mv=%h mi=%0d want 1 3 5 3", found, first_idx, min_value, min_idx);
        end
        vectors++;
        if ({mem[16'h9020], mem[16'h9021]} !== {32'h8000_0303, 32'd5}) begin
            miscompares++;
            $display("FAIL ties_status: got %h %h want 80000303 00000005", mem[16'h9020], mem[16'h9021]);
        end
    endtask

    task automatic test_wrap;
        int lat;
        logic ef;
        logic [7:0] efi, emi;
        logic [31:0] emv, tg;
        logic [50:0] first_res;
        for (int i = 0; i < N; i++) begin
            mem[16'hFFF8 + 16'(i)] = $urandom_range(0, 40);
            mem[16'h0400 + 16'(i)] = mem[16'hFFF8 + 16'(i)];
        end
        tg = 32'd12;
        model(16'hFFF8, tg, ef, efi, emv, emi);
        run_scan(16'hFFF8, 16'h9030, tg, lat);
        first_res = {ef, efi, emv, emi, 2'b00};
        vectors++;
        if ({found, first_idx, min_value, min_idx} !== {ef, efi, emv, emi}) begin
            miscompares++;
            $display("FAIL wrap_result: got f=%b fi=%0d mv=%h mi=%0d want %b %0d %h %0d", found, first_idx, min_value, min_idx, ef, efi, emv, emi);
        end
        run_scan(16'h0400, 16'h9040, tg, lat);
        vectors++;
        if ({found, first_idx, min_value, min_idx, 2'b00} !== first_res) begin
            miscompares++;
            $display("FAIL wrap_vs_flat: got f=%b fi=%0d mv=%h mi=%0d want %h", found, first_idx, min_value, min_idx, first_res);
        end
        vectors++;
        if ({mem[16'h9030], mem[16'h9031]} !== {mem[16'h9040], mem[16'h9041]}) begin
            miscompares++;
            $display("FAIL wrap_status: got %h %h want %h %h", mem[16'h9030], mem[16'h9031], mem[16'h9040], mem[16'h9041]);
        end
    endtask

    task automatic test_random;
        int lat;
        logic ef;
        logic [7:0] efi, emi;
        logic [31:0] emv, tg;
        logic [15:0] b, sa;
        for (int k = 0; k < 10; k++) begin
            b = 16'($urandom_range(0, 16'h7000));
            sa = 16'hC000 + 16'($urandom_range(0, 255) * 2);
            for (int i = 0; i < N; i++)
                mem[b + 16'(i)] = (k % 2 == 0) ? $urandom_range(0, 31) : $urandom;
            if (k == 2) mem[b] = 32'hFFFF_FFFF;
            tg = (k == 1) ? 32'd0 : (k == 2) ? 32'hFFFF_FFFF : (k % 2 == 0) ? $urandom_range(0, 8) : $urandom;
            model(b, tg, ef, efi, emv, emi);
            run_scan(b, sa, tg, lat);
            vectors++;
            if (lat !== N + 4) begin miscompares++; $display("FAIL rand%0d_latency: got %0d want %0d", k, lat, N + 4); end
            vectors++;
            if ({found, first_idx, min_value, min_idx} !== {ef, efi, emv, emi}) begin
                miscompares++;
                $display("FAIL rand%0d_result: got f=%b fi=%0d mv=%h mi=%0d want %b %0d %h %0d", k, found, first_idx, min_value, min_idx, ef, efi, emv, emi);
            end
            vectors++;
            if ({mem[sa], mem[sa + 16'd1]} !== {ef, 15'b0, efi, emi, emv}) begin
                miscompares++;
                $display("FAIL rand%0d_status: got %h %h want %h %h", k, mem[sa], mem[sa + 16'd1], {ef, 15'b0, efi, emi}, emv);
            end
        end
    endtask

    task automatic test_reset_midscan;
        int lat, w0;
        logic ef;
        logic [7:0] efi, emi;
        logic [31:0] emv;
        for (int i = 0; i < N; i++) mem[16'h0500 + 16'(i)] = $urandom;
        model(16'h0500, 32'h4000_0000, ef, efi, emv, emi);
        w0 = writes;
        cur_sa = 16'h9050;
        @(negedge clk);
        result_addr = 16'h0500; status_addr = 16'h9050; target = 32'h4000_0000; start = 1;
        @(posedge clk);
        #1 start = 0;
        repeat (9) @(posedge clk);
        #1 reset_n = 0;
        @(posedge clk);
        #1 test_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        repeat (N + 8) @(posedge clk);
        #1;
        vectors++;
        if (writes !== w0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_quiet: got writes=%0d done=%b want writes=%0d done=0", writes, done, w0);
        end
        run_scan(16'h0500, 16'h9050, 32'h4000_0000, lat);
        vectors++;
        if ({found, first_idx, min_value, min_idx} !== {ef, efi, emv, emi} || lat !== N + 4) begin
            miscompares++;
            $display("FAIL midreset_rescan: got f=%b fi=%0d mv=%h mi=%0d lat=%0d want %b %0d %h %0d %0d", found, first_idx, min_value, min_idx, lat, ef, efi, emv, emi, N + 4);
        end
    endtask

    task automatic test_back_to_back;
        int e, k, w0;
        int d[3];
        logic ef;
        logic [7:0] efi, emi;
        logic [31:0] emv;
        for (int i = 0; i < N; i++) mem[16'h0600 + 16'(i)] = $urandom_range(0, 1000);
        model(16'h0600, 32'd100, ef, efi, emv, emi);
        w0 = writes; e = 0; k = 0;
        d = '{0, 0, 0};
        cur_sa = 16'h9060;
        @(negedge clk);
        result_addr = 16'h0600; status_addr = 16'h9060; target = 32'd100; start = 1;
        while (k < 3 && e < 200) begin
            @(posedge clk);
            #1;
            if (done) begin d[k] = e; k++; end
            e++;
        end
        start = 0;
        vectors++;
        if (d[0] !== N + 4 || d[1] - d[0] !== N + 5 || d[2] - d[1] !== N + 5) begin
            miscompares++;
            $display("FAIL b2b_spacing: got done at %0d %0d %0d want %0d then every %0d", d[0], d[1], d[2], N + 4, N + 5);
        end
        vectors++;
        if (writes - w0 !== 6) begin
            miscompares++;
            $display("FAIL b2b_writes: got %0d want 6", writes - w0);
        end
        vectors++;
        if ({found, first_idx, min_value, min_idx} !== {ef, efi, emv, emi}) begin
            miscompares++;
            $display("FAIL b2b_result: got f=%b fi=%0d mv=%h mi=%0d want %b %0d %h %0d", found, first_idx, min_value, min_idx, ef, efi, emv, emi);
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (done !== 1'b0 || mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle: got done=%b we=%b want 0 0", done, mem_we);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 test_reset();
        reset_n = 1;
        test_ascending();
        test_strict();
        test_ties();
        test_wrap();
        test_random();
        test_reset_midscan();
        test_back_to_back();
        vectors++;
        if (bad_writes !== 0) begin
            miscompares++;
            $display("FAIL write_addresses: got %0d stray writes want 0", bad_writes);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
